// File: rtl/core_pkg.sv
// Shared core definitions: pc_gen state encoding and common constants.
package core_pkg;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} pc_gen_state_t;

    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen <-> fetch/decode/mem signal bundle.
// PC_GEN_ALIGN_CHECK_EN adds the MISALIGN_SG output.
interface pc_gen_if;

    logic        DEC2IF_POP_SI;
    logic [31:0] PC_RD;
    logic        DEC2IF_EMPTY_SD;
    logic        EXCEPTION_SM;
    logic [31:0] MTVEC_VALUE_RM;
    logic        MRET_SM;
    logic [31:0] MEPC_SM;
    logic        BRANCH_TAKEN_SD;
    logic [31:0] BRANCH_ADR_SD;
    logic        IF2DEC_FLUSH_SD;
    logic [31:0] NEXT_PC_RG;
`ifdef PC_GEN_ALIGN_CHECK_EN
    logic        MISALIGN_SG;
`endif

    modport master (
        input  DEC2IF_POP_SI,
        input  EXCEPTION_SM,
        input  MTVEC_VALUE_RM,
        input  MRET_SM,
        input  MEPC_SM,
        input  BRANCH_TAKEN_SD,
        input  BRANCH_ADR_SD,
        output PC_RD,
        output DEC2IF_EMPTY_SD,
        output IF2DEC_FLUSH_SD,
        output NEXT_PC_RG
`ifdef PC_GEN_ALIGN_CHECK_EN
        , output MISALIGN_SG
`endif
    );

    modport slave (
        output DEC2IF_POP_SI,
        output EXCEPTION_SM,
        output MTVEC_VALUE_RM,
        output MRET_SM,
        output MEPC_SM,
        output BRANCH_TAKEN_SD,
        output BRANCH_ADR_SD,
        input  PC_RD,
        input  DEC2IF_EMPTY_SD,
        input  IF2DEC_FLUSH_SD,
        input  NEXT_PC_RG
`ifdef PC_GEN_ALIGN_CHECK_EN
        , input MISALIGN_SG
`endif
    );

endinterface

// File: rtl/sync_fifo_clr.sv
// Synchronous FIFO with synchronous clear and a registered head/empty flag.
module sync_fifo_clr #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2,
    parameter int unsigned PtrW  = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] dout
);

    localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [PtrW:0]    count_q, count_d;
    logic [Width-1:0] head_q, head_d;
    logic             empty_q;
    logic             pop_ok, push_ok;

    always_comb begin
        pop_ok     = pop && (count_q != '0);
        push_ok    = push && ((count_q != FullCnt) || pop_ok);
        rd_ptr_nxt = rd_ptr_q + 1'b1;

        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end

        // Head follows the entry behind the popped one, or the incoming
        // word when the queue would otherwise run dry.
        head_d = head_q;
        if (pop_ok) begin
            if (count_q > (PtrW+1)'(1)) begin
                head_d = mem_q[rd_ptr_nxt];
            end else if (push_ok) begin
                head_d = din;
            end
        end else if ((count_q == '0) && push_ok) begin
            head_d = din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            count_q <= count_d;
            head_q  <= head_d;
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign full  = (count_q == FullCnt);
    assign empty = empty_q;
    assign dout  = head_q;

endmodule

// File: rtl/pc_gen.sv
// Sequential PC generator feeding the dec2if queue, with redirect handling.
// PC_GEN_ALIGN_CHECK_EN: misaligned redirect targets are replaced by MTVEC.
module pc_gen
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_ADR = 32'h0001_0000,
    parameter int unsigned DEPTH     = 2
) (
    input logic      clk,
    input logic      reset_n,
    pc_gen_if.master bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    pc_gen_state_t state_q;
    logic [31:0]   next_pc_q;
    logic [31:0]   target;
    logic [31:0]   load_pc;
    logic [31:0]   head;
    logic          redirect;
    logic          pop_req;
    logic          push_req;
    logic          fifo_full;
    logic          fifo_empty;
    logic          flush_q;

    always_comb begin
        redirect = (bus.EXCEPTION_SM || bus.MRET_SM || bus.BRANCH_TAKEN_SD) && (state_q != BOOT);
        if (bus.EXCEPTION_SM) begin
            target = bus.MTVEC_VALUE_RM;
        end else if (bus.MRET_SM) begin
            target = bus.MEPC_SM;
        end else begin
            target = bus.BRANCH_ADR_SD;
        end
        pop_req  = (state_q == RUN) && bus.DEC2IF_POP_SI && !redirect;
        push_req = (state_q == RUN) && !redirect && (!fifo_full || (pop_req && !fifo_empty));
    end

`ifdef PC_GEN_ALIGN_CHECK_EN
    logic misalign;
    logic misalign_q;
    assign misalign        = (target[1:0] != 2'b00);
    assign load_pc         = misalign ? bus.MTVEC_VALUE_RM : target;
    assign bus.MISALIGN_SG = misalign_q;
`else
    assign load_pc = target;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BOOT;
            next_pc_q <= RESET_ADR;
            flush_q   <= 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            flush_q <= 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
            unique case (state_q)
                BOOT: state_q <= RUN;
                RUN, FLUSH: begin
                    // A redirect during FLUSH restarts the flush with the newer target.
                    if (redirect) begin
                        state_q   <= FLUSH;
                        flush_q   <= 1'b1;
                        next_pc_q <= load_pc;
`ifdef PC_GEN_ALIGN_CHECK_EN
                        misalign_q <= misalign;
`endif
                    end else begin
                        state_q <= RUN;
                        if (push_req) begin
                            next_pc_q <= next_pc_q + PC_INC;
                        end
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    sync_fifo_clr #(
        .Width (32),
        .Depth (DEPTH),
        .PtrW  (PTR_W)
    ) u_dec2if_q (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (redirect),
        .push    (push_req),
        .pop     (pop_req),
        .din     (next_pc_q),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dout    (head)
    );

    assign bus.PC_RD           = head;
    assign bus.DEC2IF_EMPTY_SD = fifo_empty;
    assign bus.IF2DEC_FLUSH_SD = flush_q;
    assign bus.NEXT_PC_RG      = next_pc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: scoreboard of expected PCs drained by pops.
`timescale 1ns/1ps
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0001_0000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pc_gen_if bif ();

    pc_gen #(
        .RESET_ADR (RST_PC),
        .DEPTH     (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.master)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic clear_redirects();
        bif.EXCEPTION_SM    = 1'b0;
        bif.MRET_SM         = 1'b0;
        bif.BRANCH_TAKEN_SD = 1'b0;
    endtask

    // Pops with POP held high, comparing each valid head against the scoreboard.
    task automatic sb_drain(input string name);
        int budget = 40;
        logic [31:0] e;
        bif.DEC2IF_POP_SI = 1'b1;
        while (exp_q.size() > 0 && budget > 0) begin
            if (bif.DEC2IF_EMPTY_SD === 1'b0) begin
                e = exp_q.pop_front();
                total++;
                if (bif.PC_RD !== e) begin
                    bad++;
                    $display("FAIL %s: PC_RD=%h expected %h", name, bif.PC_RD, e);
                end
            end
            @(negedge clk);
            budget--;
        end
        bif.DEC2IF_POP_SI = 1'b0;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: timeout with %0d entries pending, got 0 expected 0", name,
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bif.DEC2IF_POP_SI  = 1'b0;
        bif.MTVEC_VALUE_RM = 32'h0000_0100;
        bif.MEPC_SM        = 32'h0;
        bif.BRANCH_ADR_SD  = 32'h0;
        clear_redirects();
        repeat (2) @(negedge clk);
        total++;
        if (bif.DEC2IF_EMPTY_SD !== 1'b1 || bif.IF2DEC_FLUSH_SD !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: empty=%b flush=%b expected 1 0",
                     bif.DEC2IF_EMPTY_SD, bif.IF2DEC_FLUSH_SD);
        end
        total++;
        if (bif.PC_RD !== 32'h0 || bif.NEXT_PC_RG !== RST_PC) begin
            bad++;
            $display("FAIL reset_pc: PC_RD=%h NEXT=%h expected 0 %h", bif.PC_RD,
                     bif.NEXT_PC_RG, RST_PC);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (bif.DEC2IF_EMPTY_SD !== 1'b1) begin
            bad++;
            $display("FAIL boot_empty: empty=%b expected 1", bif.DEC2IF_EMPTY_SD);
        end
        @(negedge clk);
        total++;
        if (bif.DEC2IF_EMPTY_SD !== 1'b0 || bif.PC_RD !== RST_PC) begin
            bad++;
            $display("FAIL first_valid: empty=%b PC_RD=%h expected 0 %h",
                     bif.DEC2IF_EMPTY_SD, bif.PC_RD, RST_PC);
        end
    endtask

    task automatic test_stream();
        push_seq(RST_PC, 8);
        sb_drain("stream");
    endtask

    task automatic test_fill();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (bif.PC_RD !== RST_PC || bif.DEC2IF_EMPTY_SD !== 1'b0) begin
            bad++;
            $display("FAIL fill_head: PC_RD=%h empty=%b expected %h 0", bif.PC_RD,
                     bif.DEC2IF_EMPTY_SD, RST_PC);
        end
        total++;
        if (bif.NEXT_PC_RG !== RST_PC + 32'd8) begin
            bad++;
            $display("FAIL fill_next: NEXT=%h expected %h", bif.NEXT_PC_RG, RST_PC + 32'd8);
        end
        push_seq(RST_PC, 6);
        sb_drain("fill_resume");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_branch_full();
        bif.BRANCH_TAKEN_SD = 1'b1;
        bif.BRANCH_ADR_SD   = 32'h0000_2000;
        @(negedge clk);
        clear_redirects();
        total++;
        if (bif.IF2DEC_FLUSH_SD !== 1'b1 || bif.DEC2IF_EMPTY_SD !== 1'b1) begin
            bad++;
            $display("FAIL branch_flush: flush=%b empty=%b expected 1 1",
                     bif.IF2DEC_FLUSH_SD, bif.DEC2IF_EMPTY_SD);
        end
        @(negedge clk);
        total++;
        if (bif.IF2DEC_FLUSH_SD !== 1'b0 || bif.DEC2IF_EMPTY_SD !== 1'b1) begin
            bad++;
            $display("FAIL branch_refill: flush=%b empty=%b expected 0 1",
                     bif.IF2DEC_FLUSH_SD, bif.DEC2IF_EMPTY_SD);
        end
        @(negedge clk);
        total++;
        if (bif.DEC2IF_EMPTY_SD !== 1'b0) begin
            bad++;
            $display("FAIL branch_valid: empty=%b expected 0", bif.DEC2IF_EMPTY_SD);
        end
        push_seq(32'h0000_2000, 3);
        sb_drain("branch_seq");
    endtask

    task automatic test_priority();
        int flushes;
        for (int c = 0; c < 2; c++) begin
            bif.EXCEPTION_SM    = (c == 0);
            bif.MRET_SM         = 1'b1;
            bif.BRANCH_TAKEN_SD = 1'b1;
            bif.MEPC_SM         = 32'h0000_0300;
            bif.BRANCH_ADR_SD   = 32'h0000_2000;
            flushes = 0;
            repeat (4) begin
                @(negedge clk);
                clear_redirects();
                if (bif.IF2DEC_FLUSH_SD === 1'b1) flushes++;
            end
            total++;
            if (flushes != 1) begin
                bad++;
                $display("FAIL prio_pulses[%0d]: flush cycles=%0d expected 1", c, flushes);
            end
            push_seq((c == 0) ? 32'h0000_0100 : 32'h0000_0300, 3);
            sb_drain("prio_seq");
        end
    endtask

    task automatic test_wrap();
        bif.BRANCH_TAKEN_SD = 1'b1;
        bif.BRANCH_ADR_SD   = 32'hFFFF_FFFC;
        repeat (3) begin
            @(negedge clk);
            clear_redirects();
        end
        push_seq(32'hFFFF_FFFC, 3);
        sb_drain("wrap");
    endtask

    task automatic test_back_to_back();
        bif.BRANCH_TAKEN_SD = 1'b1;
        bif.BRANCH_ADR_SD   = 32'h0000_3000;
        @(negedge clk);
        bif.BRANCH_ADR_SD = 32'h0000_4000;
        total++;
        if (bif.IF2DEC_FLUSH_SD !== 1'b1) begin
            bad++;
            $display("FAIL b2b_flush1: flush=%b expected 1", bif.IF2DEC_FLUSH_SD);
        end
        @(negedge clk);
        clear_redirects();
        total++;
        if (bif.IF2DEC_FLUSH_SD !== 1'b1 || bif.DEC2IF_EMPTY_SD !== 1'b1) begin
            bad++;
            $display("FAIL b2b_flush2: flush=%b empty=%b expected 1 1",
                     bif.IF2DEC_FLUSH_SD, bif.DEC2IF_EMPTY_SD);
        end
        @(negedge clk);
        total++;
        if (bif.IF2DEC_FLUSH_SD !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: flush=%b expected 0", bif.IF2DEC_FLUSH_SD);
        end
        @(negedge clk);
        push_seq(32'h0000_4000, 2);
        sb_drain("b2b_seq");
    endtask

    task automatic test_reset_in_flush();
        bif.BRANCH_TAKEN_SD = 1'b1;
        bif.BRANCH_ADR_SD   = 32'h0000_5000;
        @(negedge clk);
        clear_redirects();
        total++;
        if (bif.IF2DEC_FLUSH_SD !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_flush: flush=%b expected 1", bif.IF2DEC_FLUSH_SD);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (bif.IF2DEC_FLUSH_SD !== 1'b0 || bif.DEC2IF_EMPTY_SD !== 1'b1 ||
            bif.NEXT_PC_RG !== RST_PC) begin
            bad++;
            $display("FAIL rst_async: flush=%b empty=%b NEXT=%h expected 0 1 %h",
                     bif.IF2DEC_FLUSH_SD, bif.DEC2IF_EMPTY_SD, bif.NEXT_PC_RG, RST_PC);
        end
        repeat (2) @(negedge clk);
        bif.DEC2IF_POP_SI = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (bif.DEC2IF_EMPTY_SD !== 1'b1 || bif.IF2DEC_FLUSH_SD !== 1'b0) begin
            bad++;
            $display("FAIL rst_boot: empty=%b flush=%b expected 1 0",
                     bif.DEC2IF_EMPTY_SD, bif.IF2DEC_FLUSH_SD);
        end
        @(negedge clk);
        total++;
        if (bif.DEC2IF_EMPTY_SD !== 1'b0) begin
            bad++;
            $display("FAIL rst_restart: empty=%b expected 0", bif.DEC2IF_EMPTY_SD);
        end
        push_seq(RST_PC, 3);
        sb_drain("rst_seq");
    endtask

`ifdef PC_GEN_ALIGN_CHECK_EN
    task automatic test_misalign();
        bif.MTVEC_VALUE_RM  = 32'h0000_0100;
        bif.BRANCH_TAKEN_SD = 1'b1;
        bif.BRANCH_ADR_SD   = 32'h0000_2002;
        @(negedge clk);
        clear_redirects();
        total++;
        if (bif.MISALIGN_SG !== 1'b1 || bif.IF2DEC_FLUSH_SD !== 1'b1) begin
            bad++;
            $display("FAIL misalign_pulse: mis=%b flush=%b expected 1 1", bif.MISALIGN_SG,
                     bif.IF2DEC_FLUSH_SD);
        end
        @(negedge clk);
        total++;
        if (bif.MISALIGN_SG !== 1'b0) begin
            bad++;
            $display("FAIL misalign_end: mis=%b expected 0", bif.MISALIGN_SG);
        end
        @(negedge clk);
        push_seq(32'h0000_0100, 2);
        sb_drain("misalign_seq");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_branch_full();
        test_priority();
        test_wrap();
        test_back_to_back();
`ifdef PC_GEN_ALIGN_CHECK_EN
        test_misalign();
`endif
        test_reset_in_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
